pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 96, payload width (instruction + NPC + BDS, 3 x 32).
REQ-002 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.
REQ-003 SHALL have parameter NOP_VALUE, default all-zero DATA_W, the payload loaded on reset and on flush.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 SHALL have port i_clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port i_valid, input, 1, upstream payload valid.
REQ-008 SHALL have port o_ready, output, 1, stage can accept upstream payload.
REQ-009 SHALL have port i_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port i_flush, input, 1, discard all held and incoming payload.
REQ-011 SHALL have port o_valid, output, 1, downstream payload valid.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts payload.
REQ-013 SHALL have port o_data, output, DATA_W, downstream payload, driven directly from the main register.
REQ-014 SHALL have port o_count, output, 2, entries held (0..2).
REQ-015 SHALL have port o_stall_cnt, output, CNT_W, saturating count of stall cycles.

Function
REQ-016 SHALL treat a transfer as accepted when i_valid and o_ready are both high, and as delivered when o_valid and i_ready are both high.
REQ-017 SHALL implement states EMPTY (count 0), FULL (count 1) and SKID (count 2); SKID is unreachable when SKID_EN=0.
REQ-018 In EMPTY: o_valid=0, o_ready=1; on accept, main <= i_data, go to FULL.
REQ-019 In FULL: o_valid=1; accept+deliver -> main <= i_data, stay FULL; deliver only -> EMPTY; accept only -> skid <= i_data, go to SKID.
REQ-020 In SKID: o_valid=1, o_ready=0; on deliver, main <= skid, go to FULL; otherwise hold.
REQ-021 With SKID_EN=1, o_ready SHALL be a function of state only (high in EMPTY and FULL), with no combinational path from i_ready.
REQ-022 With SKID_EN=0, o_ready SHALL equal i_ready OR NOT o_valid, and FULL with accept-only SHALL be impossible.
REQ-023 Latency SHALL be one cycle: data accepted in cycle N appears on o_data with o_valid in cycle N+1 if the stage was EMPTY, or FULL with concurrent delivery.
REQ-024 Ordering SHALL be strict FIFO; no payload is duplicated or dropped except by flush or reset.
REQ-025 i_flush SHALL force EMPTY next cycle, load main and skid with NOP_VALUE, and discard any same-cycle accept; o_ready is unaffected during the flush cycle.
REQ-026 When flush and accept coincide, the upstream SHALL see a handshake but the payload SHALL be lost; this is intended, for squashing wrong-path fetches.
REQ-027 o_stall_cnt SHALL increment by 1 each cycle with o_valid=1 and i_ready=0, saturate at 2^CNT_W-1, and not clear on flush.
REQ-028 When o_valid=0, o_data SHALL equal its last value, or NOP_VALUE after reset or flush.

Reset
REQ-029 On i_reset: state EMPTY, o_valid=0, o_count=0, main=skid=NOP_VALUE, o_stall_cnt=0.
REQ-030 With SKID_EN=1, o_ready SHALL read 1 in the first cycle after reset.
REQ-031 i_reset SHALL take priority over i_flush and all handshakes, including mid-SKID.

Structure
REQ-032 State encoding (EMPTY/FULL/SKID) and the default DATA_W of 96 SHALL live in the shared pipeline package.
REQ-033 The saturating counter SHALL be a sub-module sat_counter, parameterised by CNT_W, with ports increment and reset.
REQ-034 The block SHALL be instantiable as the drop-in replacement for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) through DATA_W alone.

Verification
REQ-035 Reset, then i_valid=1, i_data=0xA, i_ready=1 for 1 cycle -> o_valid=1, o_data=0xA next cycle; o_count=1.
REQ-036 FULL(0xA), i_ready=0, accept 0xB -> SKID, o_ready=0, o_count=2; then i_ready=1 -> o_data 0xA then 0xB on consecutive cycles.
REQ-037 SKID state, i_flush=1 -> next cycle o_valid=0, o_count=0, o_data=NOP_VALUE, o_ready=1.
REQ-038 FULL with i_ready=0 held for 5 cycles -> o_stall_cnt=5; CNT_W=2 bench held 6 cycles -> o_stall_cnt=3.
REQ-039 SKID_EN=0: FULL, i_ready=0 -> o_ready=0 in the same cycle; i_ready=1 with i_valid=1 streams 0x1,0x2,0x3 at one per cycle with no bubbles.
REQ-040 Random valid/ready at 50% for 10,000 cycles against a reference queue -> output order identical, no loss, o_count never exceeds 2.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: inter-stage register state encoding
// and default payload/counter widths.
package pipe_stage_skid_pkg;

  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used to count stall cycles.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             increment,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // count up until saturated; synchronous clear
  always_ff @(posedge i_clk) begin
    if (reset)
      count <= '0;
    else if (increment && (count != '1))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with optional two-entry skid
// buffer, flush-to-NOP and a saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W    = PIPE_DATA_W,
  parameter int                SKID_EN   = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = PIPE_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam bit SKID = (SKID_EN != 0);

  skid_state_e       state_q;
  skid_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              deliver;
  logic              main_ld;
  logic              main_from_skid;
  logic              skid_ld;

  assign o_valid = (state_q != ST_EMPTY);
  assign o_data  = main_q;
  assign o_count = state_q;
  assign accept  = i_valid & o_ready;
  assign deliver = o_valid & i_ready;

  generate
    if (SKID) begin : g_skid
      assign o_ready = (state_q != ST_SKID);
    end else begin : g_single
      assign o_ready = i_ready | ~o_valid;
    end
  endgenerate

  // next-state and register load decisions
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_ld = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && deliver) begin
          main_ld = 1'b1;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end else if (accept && SKID) begin
          skid_ld = 1'b1;
          state_d = ST_SKID;
        end
      end
      ST_SKID: begin
        if (deliver) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // state register; reset beats flush
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state_q <= ST_EMPTY;
    else if (i_flush)
      state_q <= ST_EMPTY;
    else
      state_q <= state_d;
  end

  // payload registers; flush squashes any same-cycle accept
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      if (main_ld)
        main_q <= main_from_skid ? skid_q : i_data;
      if (skid_ld)
        skid_q <= i_data;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .i_clk    (i_clk),
    .reset    (i_reset),
    .increment(o_valid & ~i_ready),
    .count    (o_stall_cnt)
  );

endmodule
